rx: RTL and testbench

Receive-side matched filter and symbol slicer for the BPSK/QPSK modem. Takes the oversampled, signed baseband stream from the channel model or ADC path at UPSAMPLE samples per symbol and runs it through a full-rate root-raised-cosine FIR. It decimates at a selectable sampling phase and slices each decimated sample to a hard bit. It is the counterpart of the transmit polyphase shaping filter, and one instance serves each of the I and Q branches.

---
 rtl/rx.sv | 95 +++++++++
 tb/tb_rx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rx.sv
// Receive matched filter and slicer: full-rate FIR over the oversampled input, saturated output,
// and a hard bit decision at the selected decimation phase.
module rx #(
  parameter int unsigned UPSAMPLE   = 4,
  parameter int unsigned NCOEF      = 24,
  parameter int unsigned COEF_NBITS = 8,
  parameter int unsigned COEF_FBITS = 7,
  parameter logic [NCOEF*COEF_NBITS-1:0] COEF = '0,
  parameter int unsigned IN_NBITS   = 8,
  parameter int unsigned IN_FBITS   = 7,
  parameter int unsigned OUT_NBITS  = 8,
  parameter int unsigned OUT_FBITS  = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic signed [IN_NBITS-1:0]        rx_in,
  input  logic        [$clog2(UPSAMPLE)-1:0] phase_sel,
  output logic signed [OUT_NBITS-1:0]       rx_filt,
  output logic                              rx_bit,
  output logic                              rx_valid
);

  localparam int unsigned PW         = $clog2(UPSAMPLE);
  localparam int unsigned PROD_NBITS = IN_NBITS + COEF_NBITS;
  localparam int unsigned FULL_NBITS = IN_NBITS + COEF_NBITS + $clog2(NCOEF);
  localparam int unsigned FULL_FBITS = IN_FBITS + COEF_FBITS;
  localparam int unsigned SHIFT      = FULL_FBITS - OUT_FBITS;
  localparam int unsigned HI_NBITS   = FULL_NBITS - SHIFT - OUT_NBITS + 1;

  logic signed [IN_NBITS-1:0]   sreg [NCOEF-1];
  logic signed [IN_NBITS-1:0]   win  [NCOEF];
  logic signed [COEF_NBITS-1:0] coef_j;
  logic signed [PROD_NBITS-1:0] prod;
  logic signed [FULL_NBITS-1:0] acc;
  logic                         ovf;
  logic signed [OUT_NBITS-1:0]  filt_d;
  logic        [PW-1:0]         cnt;

  // Tap 0 sees the live input so the output register adds only one cycle of latency.
  always_comb begin
    win[0] = rx_in;
    for (int j = 1; j < NCOEF; j++) begin
      win[j] = sreg[j-1];
    end
  end

  always_comb begin
    acc    = '0;
    coef_j = '0;
    prod   = '0;
    for (int j = 0; j < NCOEF; j++) begin
      coef_j = $signed(COEF[(NCOEF-1-j)*COEF_NBITS +: COEF_NBITS]);
      prod   = PROD_NBITS'(coef_j) * PROD_NBITS'(win[j]);
      acc    = acc + $signed({{(FULL_NBITS-PROD_NBITS){prod[PROD_NBITS-1]}}, prod});
    end
  end

  // Floor by dropping fraction bits; clamp when the discarded high bits disagree with the sign.
  always_comb begin
    ovf = acc[FULL_NBITS-1 -: HI_NBITS] != {HI_NBITS{acc[FULL_NBITS-1]}};
    if (!ovf) begin
      filt_d = acc[SHIFT +: OUT_NBITS];
    end else if (acc[FULL_NBITS-1]) begin
      filt_d = {1'b1, {(OUT_NBITS-1){1'b0}}};
    end else begin
      filt_d = {1'b0, {(OUT_NBITS-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NCOEF - 1; j++) begin
        sreg[j] <= '0;
      end
      cnt      <= '0;
      rx_filt  <= '0;
      rx_bit   <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      sreg[0] <= rx_in;
      for (int j = 1; j < NCOEF - 1; j++) begin
        sreg[j] <= sreg[j-1];
      end
      cnt     <= (cnt == PW'(UPSAMPLE - 1)) ? '0 : cnt + PW'(1);
      rx_filt <= filt_d;
      if (cnt == phase_sel) begin
        rx_bit   <= ~acc[FULL_NBITS-1];
        rx_valid <= 1'b1;
      end else begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx.sv
// Bench for rx: four instances with different tap sets share one stimulus stream and are checked
// against a behavioural FIR/quantiser/phase model through an expected-result queue.
module tb_rx;

  localparam int UP = 4;
  localparam int NC = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_in = '0;
  logic [1:0] phase_sel = '0;

  wire [3:0][7:0] filt;
  wire [3:0]      bit_o;
  wire [3:0]      vld;

  typedef struct packed {
    logic [3:0][7:0] filt;
    logic [3:0]      bits;
    logic            valid;
  } exp_t;

  exp_t       exp_q[$];
  logic       sym_q[$];
  int         hist[NC-1];
  int         cnt_m = 0;
  logic [3:0] bit_m = '0;
  logic       lb_on = 1'b0;
  int         checks = 0;
  int         errors = 0;
  logic [8:0] lfsr = 9'h1FF;

  always #5 clk = ~clk;

  rx #(.COEF({NC{8'h40}})) u_pos (.clk(clk), .rst(rst), .rx_in(rx_in), .phase_sel(phase_sel),
    .rx_filt(filt[0]), .rx_bit(bit_o[0]), .rx_valid(vld[0]));
  rx #(.COEF({NC{8'hC0}})) u_neg (.clk(clk), .rst(rst), .rx_in(rx_in), .phase_sel(phase_sel),
    .rx_filt(filt[1]), .rx_bit(bit_o[1]), .rx_valid(vld[1]));
  rx #(.COEF({NC{8'h7F}})) u_sat (.clk(clk), .rst(rst), .rx_in(rx_in), .phase_sel(phase_sel),
    .rx_filt(filt[2]), .rx_bit(bit_o[2]), .rx_valid(vld[2]));
  rx #(.COEF({{4{8'h20}}, {(NC-4){8'h00}}})) u_mf (.clk(clk), .rst(rst), .rx_in(rx_in),
    .phase_sel(phase_sel), .rx_filt(filt[3]), .rx_bit(bit_o[3]), .rx_valid(vld[3]));

  function automatic int coef_of(int inst, int j);
    case (inst)
      0:       return 64;
      1:       return -64;
      2:       return 127;
      default: return (j < 4) ? 32 : 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] din);
    exp_t e;
    int   sum;
    int   q;
    @(negedge clk);
    rx_in = din;
    for (int i = 0; i < 4; i++) begin
      sum = coef_of(i, 0) * int'($signed(din));
      for (int j = 1; j < NC; j++) sum += coef_of(i, j) * hist[j-1];
      q = sum >>> 7;
      if (q > 127) q = 127;
      if (q < -128) q = -128;
      if (rst) begin
        e.filt[i] = 8'h00;
        bit_m[i]  = 1'b0;
      end else begin
        e.filt[i] = q[7:0];
        if (cnt_m == int'(phase_sel)) bit_m[i] = (sum >= 0);
      end
    end
    e.bits  = bit_m;
    e.valid = !rst && (cnt_m == int'(phase_sel));
    exp_q.push_back(e);
    if (rst) begin
      for (int j = 0; j < NC - 1; j++) hist[j] = 0;
      cnt_m = 0;
    end else begin
      for (int j = NC - 2; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = int'($signed(din));
      cnt_m   = (cnt_m + 1) % UP;
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("filt%0d", i), 32'(filt[i]), 32'(e.filt[i]));
      chk($sformatf("bit%0d", i), 32'(bit_o[i]), 32'(e.bits[i]));
      chk($sformatf("valid%0d", i), 32'(vld[i]), 32'(e.valid));
    end
    if (lb_on && vld[3]) begin
      chk("lb_pending", 32'(sym_q.size() > 0), 32'd1);
      if (sym_q.size() > 0) chk("lb_bit", 32'(bit_o[3]), 32'(sym_q.pop_front()));
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_filt%0d", i), 32'(filt[i]), 32'd0);
      chk($sformatf("rst_bit%0d", i), 32'(bit_o[i]), 32'd0);
      chk($sformatf("rst_valid%0d", i), 32'(vld[i]), 32'd0);
    end
    bit_m = '0;
    sym_q.delete();
    repeat (n) step(8'($urandom));
    rst = 1'b0;
  endtask

  task automatic send_symbols(input int n);
    logic b;
    for (int k = 0; k < n; k++) begin
      b    = lfsr[8];
      lfsr = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
      sym_q.push_back(b);
      repeat (UP) step(b ? 8'h40 : 8'hC0);
    end
  endtask

  initial begin
    int gap;
    for (int j = 0; j < NC - 1; j++) hist[j] = 0;

    // Reset held with random input, then release with phase 0.
    rst = 1'b1;
    phase_sel = 2'd0;
    repeat (5) step(8'($urandom));
    rst = 1'b0;

    // Impulse response of the constant-tap instances.
    step(8'h7F);
    repeat (30) step(8'h00);

    // Saturation in both directions.
    repeat (30) step(8'h7F);
    repeat (30) step(8'h80);

    // Decimation phase and a live phase change just after a strobe.
    phase_sel = 2'd2;
    repeat (12) step(8'($urandom));
    gap = 0;
    do begin
      step(8'($urandom));
      gap++;
    end while (!vld[0] && gap < 8);
    chk("strobe_found", 32'(vld[0]), 32'd1);
    phase_sel = 2'd1;
    gap = 0;
    do begin
      step(8'($urandom));
      gap++;
    end while (!vld[0] && gap < 2 * UP);
    chk("phase_switch_gap", 32'(gap), 32'd3);
    repeat (8) step(8'($urandom));

    // PRBS-9 loopback through a rectangular matched filter, with a reset mid-stream.
    phase_sel = 2'd3;
    do_reset(3);
    lb_on = 1'b1;
    send_symbols(500);
    do_reset(3);
    send_symbols(500);
    chk("lb_drained", 32'(sym_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
